// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded fields, forwards
// EX/MEM and MEM/WB results into the operands, and inserts load-use bubbles.

module id_ex_fwd_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] addr_q,
    input  logic [DATA_WIDTH-1:0]     data_q,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_write_reg,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_write_reg,
    input  logic [DATA_WIDTH-1:0]     memwb_data,
    output logic [DATA_WIDTH-1:0]     y
);
    logic hit_exmem, hit_memwb;

    // Register 0 is hardwired, so a write to it is never a forwarding source.
    assign hit_exmem = exmem_reg_write && (exmem_write_reg != '0) && (exmem_write_reg == addr_q);
    assign hit_memwb = memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == addr_q);

    always_comb begin
        y = data_q;
        if (hit_exmem)      y = exmem_result;
        else if (hit_memwb) y = memwb_data;
    end
endmodule

module id_ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [4:0]                id_shamt,
    input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    input  logic                      id_alu_src,
    input  logic [REG_ADDR_WIDTH-1:0] id_write_reg,
    input  logic [3:0]                id_ctrl,
    input  logic                      flush,
    input  logic                      stall,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_write_reg,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_write_reg,
    input  logic [DATA_WIDTH-1:0]     memwb_data,
    output logic [ALU_OP_WIDTH-1:0]   ALUOperation,
    output logic [DATA_WIDTH-1:0]     A,
    output logic [DATA_WIDTH-1:0]     B,
    output logic [4:0]                shamt,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_write_reg,
    output logic [3:0]                ex_ctrl,
    output logic                      hazard_stall
);
    typedef struct packed {
        logic [1:0][REG_ADDR_WIDTH-1:0] src_addr;   // [0] = rs, [1] = rt
        logic [1:0][DATA_WIDTH-1:0]     src_data;
        logic [DATA_WIDTH-1:0]          imm;
        logic [4:0]                     shamt;
        logic [ALU_OP_WIDTH-1:0]        alu_op;
        logic                           alu_src;
        logic [REG_ADDR_WIDTH-1:0]      write_reg;
        logic [3:0]                     ctrl;       // {reg_write, mem_read, mem_write, mem_to_reg}
    } ex_regs_t;

    ex_regs_t                   id_d, ex_q;
    logic [1:0][DATA_WIDTH-1:0] fwd;

    always_comb begin
        id_d.src_addr  = {id_rt_addr, id_rs_addr};
        id_d.src_data  = {id_rt_data, id_rs_data};
        id_d.imm       = id_imm;
        id_d.shamt     = id_shamt;
        id_d.alu_op    = id_alu_op;
        id_d.alu_src   = id_alu_src;
        id_d.write_reg = id_write_reg;
        id_d.ctrl      = id_ctrl;
    end

    // Load in EX whose destination is read by the instruction in ID.
    assign hazard_stall = ex_q.ctrl[2] && (ex_q.write_reg != '0) &&
                          ((ex_q.write_reg == id_rs_addr) || (ex_q.write_reg == id_rt_addr));

    // A bubble is the all-zero record: no write, no forward, AND op.
    always_ff @(posedge clk) begin
        if (!reset)
            ex_q <= '0;
        else if (flush)
            ex_q <= '0;
        else if (!stall) begin
            if (hazard_stall) ex_q <= '0;
            else              ex_q <= id_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        id_ex_fwd_mux #(
            .DATA_WIDTH     (DATA_WIDTH),
            .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
        ) u_fwd (
            .addr_q          (ex_q.src_addr[i]),
            .data_q          (ex_q.src_data[i]),
            .exmem_reg_write (exmem_reg_write),
            .exmem_write_reg (exmem_write_reg),
            .exmem_result    (exmem_result),
            .memwb_reg_write (memwb_reg_write),
            .memwb_write_reg (memwb_write_reg),
            .memwb_data      (memwb_data),
            .y               (fwd[i])
        );
    end

    assign A             = fwd[0];
    assign ex_store_data = fwd[1];
    assign B             = ex_q.alu_src ? ex_q.imm : fwd[1];
    assign ALUOperation  = ex_q.alu_op;
    assign shamt         = ex_q.shamt;
    assign ex_write_reg  = ex_q.write_reg;
    assign ex_ctrl       = ex_q.ctrl;
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the pipelined MIPS datapath; sits directly upstream of the 32-bit ALU and drives its ALUOperation, A, B and shamt inputs.
- Latches decoded instruction fields and register-file reads, and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts a one-cycle bubble, and requests an ID/IF stall.

Parameters:
DATA_WIDTH, 32, width of operands, immediate and forwarded results
REG_ADDR_WIDTH, 5, register-file address width
ALU_OP_WIDTH, 4, width of the ALU operation code

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset
id_rs_addr / id_rt_addr  input  REG_ADDR_WIDTH each  source register numbers from ID
id_rs_data / id_rt_data  input  DATA_WIDTH each  register-file read data from ID
id_imm  input  DATA_WIDTH  sign-extended immediate
id_shamt  input  5  shift amount field
id_alu_op  input  ALU_OP_WIDTH  decoded ALU operation
id_alu_src  input  1  1 = B operand is immediate
id_write_reg  input  REG_ADDR_WIDTH  destination register
id_ctrl  input  4  {reg_write, mem_read, mem_write, mem_to_reg}
flush  input  1  squash the instruction entering EX (branch taken)
stall  input  1  hold EX contents (downstream stall)
exmem_reg_write / exmem_write_reg / exmem_result  input  1 / REG_ADDR_WIDTH / DATA_WIDTH  EX/MEM forwarding source
memwb_reg_write / memwb_write_reg / memwb_data  input  1 / REG_ADDR_WIDTH / DATA_WIDTH  MEM/WB forwarding source
ALUOperation  output  ALU_OP_WIDTH  to ALU
A / B  output  DATA_WIDTH each  forwarded operands to ALU
shamt  output  5  to ALU
ex_store_data  output  DATA_WIDTH  forwarded rt value for stores
ex_write_reg  output  REG_ADDR_WIDTH  registered destination register
ex_ctrl  output  4  registered id_ctrl
hazard_stall  output  1  load-use stall request to PC/IF/ID (combinational)

Behaviour:
- Registered state: rs/rt addr, rs/rt data, imm, shamt, alu_op, alu_src, write_reg, ctrl. All registers update on the rising clk edge only.
- Reset (reset == 0 at an edge) clears all registers to 0. ALUOperation = 0 (AND), shamt = 0, ex_write_reg = 0, ex_ctrl = 0, hazard_stall = 0. A = B = ex_store_data = 0, because the registered addresses are 0 and register 0 is never forwarded. Reset overrides everything, including mid-stall.
- hazard_stall = ex_ctrl.mem_read & (ex_write_reg != 0) & (ex_write_reg == id_rs_addr | ex_write_reg == id_rt_addr). It is asserted regardless of id_alu_src.
- Update priority at each edge:
  1. reset
  2. flush: load bubble
  3. stall: hold all registers
  4. hazard_stall: load bubble
  5. otherwise load ID inputs
- Bubble: ctrl = 0, write_reg = 0, alu_op = 0, rs/rt addr = 0. Data fields are don't-care but must be zeroed. A bubble therefore never forwards and never writes.
- Forwarding for operand X in {rs, rt}:
  - If exmem_reg_write & exmem_write_reg != 0 & exmem_write_reg == X_addr_q, use exmem_result.
  - Else if the same condition holds on the memwb_* inputs, use memwb_data.
  - Else use X_data_q.
  - EX/MEM has priority when both sources match.
- Outputs:
  - A = forwarded rs.
  - ex_store_data = forwarded rt.
  - B = imm_q when alu_src_q, else forwarded rt.
  - A, B and ex_store_data are combinational from registers plus forwarding inputs: zero added latency inside EX.
- Latency: ID fields appear on the outputs 1 cycle after capture. A load-use pair costs exactly 1 bubble cycle.
- Simultaneous events:
  - flush with stall: flush wins, bubble loaded.
  - stall with hazard_stall: hold. hazard_stall stays asserted, since the held load is still in EX.
- Width rules: no arithmetic in the block; shamt is passed through unchanged. Widths are exact, with no truncation or extension beyond id_imm, which arrives pre-extended.

Test Plan:
1. Reset: hold reset = 0 for 2 cycles with nonzero ID inputs and exmem_reg_write = 1, exmem_write_reg = 0 -> all outputs 0, hazard_stall = 0. Release -> the next edge loads the ID inputs.
2. Plain load: id_rs_data = 0x0000_0005, id_imm = 0xFFFF_FFFC, alu_src = 1, id_alu_op = 4'b0011 -> 1 cycle later A = 5, B = 0xFFFF_FFFC, ALUOperation = 4'b0011.
3. Double forward: rs_addr_q = 8, exmem_write_reg = 8 with exmem_result = 0x11, memwb_write_reg = 8 with memwb_data = 0x22, both reg_write = 1 -> A = 0x11. Drop exmem_reg_write -> A = 0x22. Set the matching write_reg to 0 -> A = register data.
4. Load-use: EX holds lw to $t0 (reg 8), ID presents rt_addr = 8 -> hazard_stall = 1. Next edge: ex_ctrl = 0, ex_write_reg = 0, hazard_stall = 0. The following edge loads the dependent instruction.
5. Flush vs stall: assert flush and stall together -> bubble loaded. Stall alone for 3 cycles -> all outputs constant, then resume loading.
6. Store forwarding: alu_src_q = 1, rt_addr_q = 9, memwb_write_reg = 9 with memwb_data = 0xDEAD_BEEF -> ex_store_data = 0xDEAD_BEEF, while B remains imm_q.
